// File: rtl/bus_pkg.sv
// bus_pkg: com-state and controller command encodings shared by the
// serial-bus controller, its masters and the ownership watchdog.
package bus_pkg;

    localparam logic [1:0] END_COM  = 2'b00;
    localparam logic [1:0] NAK      = 2'b01;
    localparam logic [1:0] WAIT_ACK = 2'b10;
    localparam logic [1:0] COM      = 2'b11;

    localparam logic [1:0] WAIT   = 2'b00;
    localparam logic [1:0] STOP_S = 2'b01;
    localparam logic [1:0] STOP_P = 2'b10;
    localparam logic [1:0] CLEAR  = 2'b11;

endpackage

// File: rtl/threshold_counter_if.sv
// threshold_counter_if: bundle of the granted master's com state and ID plus
// the watchdog expiry flag, for wiring the watchdog into a controller or bench.
interface threshold_counter_if #(
    parameter int M_ID_WIDTH = 1
);

    logic [1:0]            cur_com_state;
    logic [M_ID_WIDTH-1:0] cur_master;
    logic                  thresh;

    modport master (output cur_com_state, output cur_master, input thresh);
    modport slave  (input cur_com_state, input cur_master, output thresh);

endinterface

// File: rtl/threshold_counter.sv
// threshold_counter: counts cycles the granted master spends in COM and raises
// a sticky, registered thresh flag once THRESH such cycles have accumulated.
module threshold_counter
    import bus_pkg::*;
#(
    parameter int THRESH     = 1000,
    parameter int M_ID_WIDTH = 1,
    parameter int CNT_WIDTH  = $clog2(THRESH + 1)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [1:0]            cur_com_state,
    input  logic [M_ID_WIDTH-1:0] cur_master,
    output logic                  thresh
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COUNT   = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    localparam logic [CNT_WIDTH:0] THRESH_W = (CNT_WIDTH + 1)'(THRESH);

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [M_ID_WIDTH-1:0] prev_master_q;
    logic [1:0]            state_q, state_d;
    logic                  thresh_q, thresh_d;
    logic [CNT_WIDTH:0]    count_inc;

    // One extra bit so the compare against THRESH can never be fooled by a wrap.
    assign count_inc = {1'b0, count_q} + 1'b1;

    always_comb begin
        count_d  = count_q;
        thresh_d = thresh_q;
        state_d  = state_q;
        if (cur_master != prev_master_q || cur_com_state == END_COM || cur_com_state == NAK) begin
            count_d  = '0;
            thresh_d = 1'b0;
            state_d  = IDLE;
        end else if (cur_com_state == COM && state_q != EXPIRED) begin
            count_d  = count_inc[CNT_WIDTH-1:0];
            thresh_d = count_inc == THRESH_W;
            state_d  = count_inc == THRESH_W ? EXPIRED : COUNT;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count_q       <= '0;
            thresh_q      <= 1'b0;
            state_q       <= IDLE;
            prev_master_q <= '0;
        end else begin
            count_q       <= count_d;
            thresh_q      <= thresh_d;
            state_q       <= state_d;
            prev_master_q <= cur_master;
        end
    end

    assign thresh = thresh_q;

endmodule

// File: tb/tb_threshold_counter.sv
// tb_threshold_counter: directed and random stimulus on a THRESH=4 and a
// THRESH=1 watchdog, checked against a run-length reference model.
module tb_threshold_counter;
    import bus_pkg::*;

    logic clk;
    logic rstN;
    logic thresh1;
    int   checks = 0;
    int   passes = 0;
    int   run0, run1;
    logic prev_m;

    threshold_counter_if #(.M_ID_WIDTH(1)) bus ();

    threshold_counter #(.THRESH(4), .M_ID_WIDTH(1)) dut (
        .clk           (clk),
        .rstN          (rstN),
        .cur_com_state (bus.cur_com_state),
        .cur_master    (bus.cur_master),
        .thresh        (bus.thresh)
    );

    threshold_counter #(.THRESH(1), .M_ID_WIDTH(1)) dut1 (
        .clk           (clk),
        .rstN          (rstN),
        .cur_com_state (bus.cur_com_state),
        .cur_master    (bus.cur_master),
        .thresh        (thresh1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Length of the current uninterrupted COM run, capped at the threshold.
    function automatic int next_run(input int run, input int t, input logic [1:0] st,
                                    input logic m, input logic pm);
        if (m != pm || st == END_COM || st == NAK) return 0;
        if (st == COM) return run + 1 > t ? t : run + 1;
        return run;
    endfunction

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            run0   <= 0;
            run1   <= 0;
            prev_m <= 1'b0;
        end else begin
            run0   <= next_run(run0, 4, bus.cur_com_state, bus.cur_master, prev_m);
            run1   <= next_run(run1, 1, bus.cur_com_state, bus.cur_master, prev_m);
            prev_m <= bus.cur_master;
        end
    end

    always @(negedge clk) begin
        if (rstN) begin
            chk("model_thresh4", int'(bus.thresh), int'(run0 >= 4));
            chk("model_count4", int'(dut.count_q), run0);
            chk("model_thresh1", int'(thresh1), int'(run1 >= 1));
            chk("model_count1", int'(dut1.count_q), run1);
        end
    end

    task automatic step(input logic [1:0] st, input logic m);
        bus.cur_com_state = st;
        bus.cur_master    = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN = 1'b0;
        bus.cur_com_state = END_COM;
        bus.cur_master    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_thresh", int'(bus.thresh), 0);
        chk("reset_count", int'(dut.count_q), 0);
        rstN = 1'b1;
        step(END_COM, 1'b0);
        chk("release_thresh", int'(bus.thresh), 0);
        chk("release_count", int'(dut.count_q), 0);
        for (int i = 1; i <= 3; i++) begin
            step(COM, 1'b0);
            chk("basic_pre", int'(bus.thresh), 0);
        end
        step(COM, 1'b0);
        chk("basic_expire", int'(bus.thresh), 1);
        chk("basic_count", int'(dut.count_q), 4);
        for (int i = 0; i < 10; i++) begin
            step(COM, 1'b0);
            chk("basic_hold", int'(bus.thresh), 1);
            chk("basic_sat", int'(dut.count_q), 4);
        end
        for (int k = 0; k < 2; k++) begin
            step(k == 0 ? END_COM : NAK, 1'b0);
            chk(k == 0 ? "clear_end" : "clear_nak", int'(bus.thresh), 0);
            for (int i = 0; i < 3; i++) begin
                step(COM, 1'b0);
                chk("clear_recount", int'(bus.thresh), 0);
            end
            step(COM, 1'b0);
            chk("clear_reexpire", int'(bus.thresh), 1);
        end
        step(END_COM, 1'b0);
        step(COM, 1'b0);
        step(COM, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(WAIT_ACK, 1'b0);
            chk("pause_hold", int'(dut.count_q), 2);
            chk("pause_thresh", int'(bus.thresh), 0);
        end
        step(COM, 1'b0);
        chk("pause_third", int'(bus.thresh), 0);
        step(COM, 1'b0);
        chk("pause_fourth", int'(bus.thresh), 1);
        step(END_COM, 1'b0);
        for (int i = 0; i < 3; i++) step(COM, 1'b0);
        chk("mchg_pre", int'(dut.count_q), 3);
        step(COM, 1'b1);
        chk("mchg_count", int'(dut.count_q), 0);
        chk("mchg_thresh", int'(bus.thresh), 0);
        for (int i = 0; i < 3; i++) begin
            step(COM, 1'b1);
            chk("mchg_recount", int'(bus.thresh), 0);
        end
        step(COM, 1'b1);
        chk("mchg_expire", int'(bus.thresh), 1);
        step(END_COM, 1'b1);
        step(COM, 1'b1);
        step(COM, 1'b1);
        chk("arst_pre", int'(dut.count_q), 2);
        #2;
        rstN = 1'b0;
        #1;
        chk("arst_count", int'(dut.count_q), 0);
        chk("arst_thresh1", int'(thresh1), 0);
        bus.cur_master = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        step(END_COM, 1'b0);
        chk("t1_idle", int'(thresh1), 0);
        step(COM, 1'b0);
        chk("t1_expire", int'(thresh1), 1);
        step(END_COM, 1'b0);
        chk("t1_clear", int'(thresh1), 0);
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 9);
            step(r < 6 ? COM : r < 8 ? WAIT_ACK : r == 8 ? END_COM : NAK,
                 $urandom_range(0, 15) == 0 ? ~bus.cur_master : bus.cur_master);
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/threshold_counter.md
# threshold_counter

Bus-ownership watchdog for the serial-bus controller. Counts clock cycles during which the currently granted master is in the active-communication state. Raises a sticky `thresh` flag once the count reaches `THRESH`; the controller uses it to interrupt or split a long transfer. Instantiated inside the controller with implicit port connections, so port names must match the controller's signal names exactly.

## Interface
Parameters:
- `THRESH`, default 1000: number of active-communication cycles before expiry; legal range ≥ 1.
- `M_ID_WIDTH`, default 1: master-ID width, equal to `$clog2(NO_MASTERS)`.
- `CNT_WIDTH`, default `$clog2(THRESH+1)`: counter width; must be able to hold the value `THRESH`.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rstN`  in  1  reset, asynchronous and active-low.
- `cur_com_state`  in  2  com state of the granted master.
- `cur_master`  in  M_ID_WIDTH  ID of the granted master.
- `thresh`  out  1  registered expiry flag.

## Operation
- Com-state encoding: `END_COM`=2'b00, `NAK`=2'b01, `WAIT_ACK`=2'b10, `COM`=2'b11.
- Internal registers:
  - `count` [CNT_WIDTH]
  - `prev_master` [M_ID_WIDTH]
  - `state`, one of IDLE, COUNT, EXPIRED
- Per rising edge, in priority order:
  1. If `cur_master != prev_master`: `count`←0, `thresh`←0, state←IDLE. The current `cur_com_state` is ignored this edge.
  2. Else if `cur_com_state` is `END_COM` or `NAK`: `count`←0, `thresh`←0, state←IDLE.
  3. Else if `cur_com_state` is `WAIT_ACK`: hold `count`, `thresh` and state.
  4. Else (`COM`):
     - IDLE or COUNT: `count`←`count`+1 and state←COUNT. If `count`+1 == `THRESH`, then instead `thresh`←1 and state←EXPIRED.
     - EXPIRED: hold. `count` saturates at `THRESH` and never wraps.
- `prev_master`←`cur_master` on every edge.
- `thresh` stays high in EXPIRED until rule 1 or rule 2 clears it.
- Arithmetic is unsigned. The increment is performed at `CNT_WIDTH`+1 bits, so there is no overflow for any legal `THRESH`.

## Timing
- Reset (asynchronous, `rstN`=0): `count`=0, `thresh`=0, `prev_master`=0, state=IDLE. All take effect immediately, without waiting for a clock edge.
- Reset release: normal operation starts at the first rising edge where `rstN`=1.
- Latency: with `THRESH`=N, `thresh` goes high on the edge that samples the N-th `COM` cycle since the last clear, i.e. it is visible in the cycle after the N-th `COM` cycle. `WAIT_ACK` cycles in between pause counting but do not reset it.
- `THRESH`=1: `thresh` goes high on the first `COM` edge.
- Clearing: `thresh` falls on the edge that samples `END_COM`, `NAK`, or a master change.
- Simultaneous events:
  - Master change together with `COM` on the same edge: clear wins, and counting resumes on the next `COM` edge.
  - Reset asserted mid-count: all registers clear immediately.
- `thresh` is a pure register output with no combinational path from inputs.

## Structure
- Shared package `bus_pkg` holds:
  - the com-state localparams `END_COM`, `NAK`, `WAIT_ACK`, `COM`, used by both the controller and the masters;
  - the controller command encodings `WAIT`, `STOP_S`, `STOP_P`, `CLEAR`.
- The local FSM state enum (IDLE/COUNT/EXPIRED) stays inside the module.
- Single flat module, no sub-modules.
- The verification bench includes a reference-model process that mirrors the counting rules.

## Test plan
All scenarios use `THRESH`=4.
- Reset: hold `rstN`=0, then release → `thresh`=0 and `count`=0. Assert `rstN` mid-count at `count`=2 → both clear immediately, without a clock edge.
- Basic expiry: `cur_com_state`=`COM` continuously → `thresh` low after edges 1–3 and high after edge 4. It stays high for 10 further `COM` cycles, with `count` held at 4.
- Pause: sequence `COM`,`COM`,`WAIT_ACK`×5,`COM`,`COM` → `thresh` rises only after the 4th `COM` edge, 9 edges total.
- Clear on end: after expiry, drive `END_COM` for one cycle → `thresh`=0 next cycle. A further 3 `COM` cycles keep it low; the 4th sets it. Repeat the check with `NAK`.
- Master change: after 3 `COM` cycles with `cur_master`=0, switch `cur_master` to 1 while still in `COM` → `count`=0 after that edge, and `thresh` rises only after 4 more `COM` edges (5 edges after the switch).
- `THRESH`=1 build: a single `COM` edge → `thresh`=1; then `END_COM` → `thresh`=0.
